// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive path: byte/word geometry,
// stored-word layout and write-side FSM encodings.
package eth_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned LAST_BIT = BYTE_W;
  localparam int unsigned WORD_W   = BYTE_W + 1;

  // One stored byte plus its end-of-frame marker
  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } rx_word_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_RECV = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/eth_rx_ram.sv
// Simple dual-port frame store: one synchronous write port, one synchronous
// read port, no reset on the array or the read register.
module eth_rx_ram
  import eth_pkg::*;
#(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_buffer.sv
// Receive frame buffer: stores MAC bytes speculatively, publishes whole good
// frames on commit, and presents them on a first-word-fall-through read port.
module eth_rx_buffer
  import eth_pkg::*;
#(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [BYTE_W-1:0]            i_mac_data,
  input  logic                         i_mac_valid,
  input  logic                         i_mac_last,
  input  logic                         i_mac_err,
  output logic [BYTE_W-1:0]            o_rdata,
  output logic                         o_rready,
  input  logic                         i_rreq,
  output logic                         o_rlast,
  output logic [$clog2(DEPTH):0]       o_frames,
  output logic [CNT_W-1:0]             o_drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  wr_state_e         state_q, state_d;
  logic [PW-1:0]     wr_spec_q, wr_cmt_q, rd_ptr_q;
  logic [PW-1:0]     frames_q;
  logic [CNT_W-1:0]  drop_q;

  logic              full_c, wr_en_c, commit_c, restore_c, drop_c;
  rx_word_t          wr_word_c;
  logic [WORD_W-1:0] ram_q;

  logic              out_v_q, out_last_q, pf_v_q, pend_q;
  logic [BYTE_W-1:0] out_data_q;
  logic [WORD_W-1:0] pf_q;
  logic              pop_c, pop_last_c, issue_c;
  logic [1:0]        occ_c;

  // Full: same index, opposite lap
  assign full_c = (wr_spec_q[AW] != rd_ptr_q[AW]) &&
                  (wr_spec_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_word_c = rx_word_t'{last: i_mac_last, data: i_mac_data};

  // Write FSM next-state and control decode
  always_comb begin
    state_d   = state_q;
    wr_en_c   = 1'b0;
    commit_c  = 1'b0;
    restore_c = 1'b0;
    drop_c    = 1'b0;
    case (state_q)
      WR_IDLE, WR_RECV: begin
        if (i_mac_valid) begin
          if (full_c) begin
            if (i_mac_last) begin
              restore_c = 1'b1;
              drop_c    = 1'b1;
              state_d   = WR_IDLE;
            end else begin
              state_d = WR_DROP;
            end
          end else begin
            wr_en_c = 1'b1;
            if (i_mac_last) begin
              state_d = WR_IDLE;
              if (i_mac_err) begin
                restore_c = 1'b1;
                drop_c    = 1'b1;
              end else begin
                commit_c = 1'b1;
              end
            end else begin
              state_d = WR_RECV;
            end
          end
        end
      end
      WR_DROP: begin
        if (i_mac_valid && i_mac_last) begin
          restore_c = 1'b1;
          drop_c    = 1'b1;
          state_d   = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= WR_IDLE;
    else          state_q <= state_d;
  end

  // Read side: at most two bytes held in output + prefetch registers,
  // counting a RAM read still in flight.
  assign pop_c      = out_v_q & i_rreq;
  assign pop_last_c = pop_c & out_last_q;
  assign occ_c      = 2'(out_v_q) + 2'(pf_v_q) + 2'(pend_q);
  assign issue_c    = (rd_ptr_q != wr_cmt_q) && ((occ_c - 2'(pop_c)) < 2'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_spec_q <= '0;
      wr_cmt_q  <= '0;
      rd_ptr_q  <= '0;
      frames_q  <= '0;
      drop_q    <= '0;
    end else begin
      if (restore_c)    wr_spec_q <= wr_cmt_q;
      else if (wr_en_c) wr_spec_q <= wr_spec_q + PW'(1);
      if (commit_c)     wr_cmt_q  <= wr_spec_q + PW'(1);
      if (issue_c)      rd_ptr_q  <= rd_ptr_q + PW'(1);
      frames_q <= frames_q + PW'(commit_c) - PW'(pop_last_c);
      if (drop_c && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
    end
  end

  // Output/prefetch shuffle: oldest available byte always lands in the output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      pf_v_q     <= 1'b0;
      pf_q       <= '0;
      pend_q     <= 1'b0;
    end else begin
      pend_q <= issue_c;
      if (!out_v_q || pop_c) begin
        if (pf_v_q) begin
          out_v_q    <= 1'b1;
          out_data_q <= pf_q[BYTE_W-1:0];
          out_last_q <= pf_q[LAST_BIT];
          pf_v_q     <= pend_q;
          if (pend_q) pf_q <= ram_q;
        end else if (pend_q) begin
          out_v_q    <= 1'b1;
          out_data_q <= ram_q[BYTE_W-1:0];
          out_last_q <= ram_q[LAST_BIT];
        end else begin
          out_v_q <= 1'b0;
        end
      end else if (pend_q) begin
        pf_v_q <= 1'b1;
        pf_q   <= ram_q;
      end
    end
  end

  eth_rx_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (wr_en_c),
    .waddr (wr_spec_q[AW-1:0]),
    .wdata (wr_word_c),
    .re    (issue_c),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_q)
  );

  assign o_rdata    = out_data_q;
  assign o_rready   = out_v_q;
  assign o_rlast    = out_last_q;
  assign o_frames   = frames_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_eth_rx_buffer.sv
// Directed bench for eth_rx_buffer: frame store, drop, overflow, wrap,
// commit/pop overlap, reset and drop-counter saturation.
module tb_eth_rx_buffer;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    mac_data;
  logic          mac_valid, mac_last, mac_err, rreq;
  logic [7:0]    rdata, s_rdata;
  logic          rready, rlast, s_rready, s_rlast;
  logic [PW-1:0] frames, s_frames;
  logic [15:0]   drop;
  logic [1:0]    s_drop;

  int checks = 0;
  int passed = 0;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  eth_rx_buffer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mac_data(mac_data), .i_mac_valid(mac_valid),
    .i_mac_last(mac_last), .i_mac_err(mac_err), .o_rdata(rdata), .o_rready(rready),
    .i_rreq(rreq), .o_rlast(rlast), .o_frames(frames), .o_drop_cnt(drop)
  );

  eth_rx_buffer #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_mac_data(mac_data), .i_mac_valid(mac_valid),
    .i_mac_last(mac_last), .i_mac_err(mac_err), .o_rdata(s_rdata), .o_rready(s_rready),
    .i_rreq(rreq), .o_rlast(s_rlast), .o_frames(s_frames), .o_drop_cnt(s_drop)
  );

  // Record every byte popped on the following rising edge
  always @(negedge clk) begin
    if (rst_n && rready && rreq) rx_q.push_back({rlast, rdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_stream(input string tag);
    int errs;
    int n;
    errs = 0;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    check({tag, " length"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) errs++;
    check({tag, " content mismatches"}, 32'(errs), 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic err);
    mac_valid = 1'b1;
    mac_data  = d;
    mac_last  = last;
    mac_err   = err;
    @(posedge clk);
    #1;
    mac_valid = 1'b0;
    mac_last  = 1'b0;
    mac_err   = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic err, input logic keep);
    for (int i = 0; i < n; i++) begin
      send_byte(8'(base + 8'(i)), (i == n - 1), err && (i == n - 1));
      if (keep) exp_q.push_back({(i == n - 1), 8'(base + 8'(i))});
    end
  endtask

  task automatic clear_queues();
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] cnt;
    rst_n = 1'b0; mac_data = '0; mac_valid = 1'b0; mac_last = 1'b0; mac_err = 1'b0; rreq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rready", 32'(rready), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset frames", 32'(frames), 32'd0);
    check("reset drop", 32'(drop), 32'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // 60-byte good frame, consumer always ready
    clear_queues();
    rreq = 1'b1;
    send_frame(60, 8'h00, 1'b0, 1'b1);
    check("A frames after commit", 32'(frames), 32'd1);
    wait_cycles(2);
    check("A rready latency", 32'(rready), 32'd1);
    check("A first byte", 32'(rdata), 32'h00);
    wait_cycles(59);
    check("A last byte data", 32'(rdata), 32'h3B);
    check("A last byte rlast", 32'(rlast), 32'd1);
    check("A frames before final pop", 32'(frames), 32'd1);
    wait_cycles(1);
    check("A rready drained", 32'(rready), 32'd0);
    check("A frames drained", 32'(frames), 32'd0);
    check_stream("A stream");

    // Bad 20-byte frame followed by a good 10-byte frame
    clear_queues();
    send_frame(20, 8'h80, 1'b1, 1'b0);
    send_frame(10, 8'h10, 1'b0, 1'b1);
    wait_cycles(15);
    check("B drop count", 32'(drop), 32'd1);
    check("B frames", 32'(frames), 32'd0);
    check_stream("B stream");

    // Overflow: three 30-byte frames into an undrained 64-byte store
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    clear_queues();
    rreq = 1'b0;
    send_frame(30, 8'h40, 1'b0, 1'b1);
    send_frame(30, 8'h60, 1'b0, 1'b1);
    send_frame(30, 8'hA0, 1'b0, 1'b0);
    wait_cycles(3);
    check("C frames", 32'(frames), 32'd2);
    check("C drop count", 32'(drop), 32'd1);
    check("C rready", 32'(rready), 32'd1);
    check("C sat frames", 32'(s_frames), 32'd2);
    check("C sat head", 32'({s_rready, s_rlast, s_rdata}), 32'h240);
    rreq = 1'b1;
    wait_cycles(70);
    check("C frames drained", 32'(frames), 32'd0);
    check_stream("C stream");

    // Back-to-back frames wrapping the store, random consumer
    clear_queues();
    cnt = 8'h00;
    fork
      begin
        for (int f = 0; f < 16; f++) begin
          int len;
          len = 6 + ((f * 7) % 12);
          send_frame(len, cnt, 1'b0, 1'b1);
          cnt = 8'(cnt + 8'(len));
          wait_cycles(len);
        end
      end
      begin
        repeat (450) begin
          @(posedge clk);
          #1;
          rreq = ($urandom_range(7) != 0);
        end
      end
    join
    rreq = 1'b1;
    wait_cycles(20);
    check("D drop unchanged", 32'(drop), 32'd1);
    check("D frames drained", 32'(frames), 32'd0);
    check_stream("D stream");

    // Commit of frame B on the same edge as the pop of frame A's last byte
    clear_queues();
    rreq = 1'b0;
    send_frame(3, 8'hA1, 1'b0, 1'b1);
    wait_cycles(5);
    check("E frames A", 32'(frames), 32'd1);
    check("E head A", 32'({rready, rdata}), 32'h1A1);
    wait_cycles(3);
    check("E head stable", 32'({rready, rlast, rdata}), 32'h2A1);
    send_byte(8'hB1, 1'b0, 1'b0);
    exp_q.push_back(9'h0B1);
    rreq = 1'b1;
    send_byte(8'hB2, 1'b0, 1'b0);
    exp_q.push_back(9'h0B2);
    send_byte(8'hB3, 1'b0, 1'b0);
    exp_q.push_back(9'h0B3);
    send_byte(8'hB4, 1'b1, 1'b0);
    exp_q.push_back(9'h1B4);
    rreq = 1'b0;
    check("E frames overlap", 32'(frames), 32'd1);
    check("E popped before B", 32'(rx_q.size()), 32'd3);
    rreq = 1'b1;
    wait_cycles(10);
    check("E frames drained", 32'(frames), 32'd0);
    check_stream("E stream");

    // Reset mid-frame with a committed byte waiting and drops counted
    clear_queues();
    rreq = 1'b0;
    send_frame(1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + 8'(i)), 1'b0, 1'b0);
    check("F pre-reset head", 32'({rready, rlast, rdata}), 32'h355);
    check("F pre-reset frames", 32'(frames), 32'd1);
    check("F pre-reset drop", 32'(drop), 32'd1);
    rst_n = 1'b0;
    #1;
    check("F reset head", 32'({rready, rlast, rdata}), 32'h000);
    check("F reset frames", 32'(frames), 32'd0);
    check("F reset drop", 32'(drop), 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    clear_queues();
    rreq = 1'b1;
    send_frame(4, 8'h70, 1'b0, 1'b1);
    wait_cycles(8);
    check("F drop after reset", 32'(drop), 32'd0);
    check("F frames drained", 32'(frames), 32'd0);
    check_stream("F stream");

    // Single-byte frames: four bad ones saturate a 2-bit counter, one good one
    clear_queues();
    for (int i = 0; i < 4; i++) send_byte(8'(8'hD0 + 8'(i)), 1'b1, 1'b1);
    send_frame(1, 8'hC3, 1'b0, 1'b1);
    wait_cycles(5);
    check("G drop count", 32'(drop), 32'd4);
    check("G saturated drop", 32'(s_drop), 32'd3);
    check("G frames", 32'(frames), 32'd0);
    check_stream("G stream");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
